npc_sim_ctrl: RTL and testbench
===============================

NPC_SIM_CTRL -- requirements
Module: npc_sim_ctrl

Interface
REQ-001 Parameter NCH, default 1, number of commit channels sampled per cycle (1..4).
REQ-002 Parameter CNT_W, default 64, width of cycle and retired-instruction counters.
REQ-003 Parameter RST_CYCLES, default 4, clock cycles core_reset stays high after reset deasserts (1..255).
REQ-004 Parameter STALL_LIMIT, default 1024, consecutive cycles with no commit that trigger the stall watchdog (0 disables).
REQ-005 Parameter MAX_CYCLES, default 0, cycles in RUN before a global timeout (0 disables).
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 commit_valid  in  NCH  one bit per channel; high means one instruction retired on that channel this cycle.
REQ-009 halt_req  in  1  core executed its halt instruction (ebreak) this cycle.
REQ-010 halt_code  in  32  exit code sampled with halt_req (a0 value).
REQ-011 core_reset  out  1  reset driven to the core under test.
REQ-012 cycle_cnt  out  CNT_W  cycles spent in RUN.
REQ-013 instret_cnt  out  CNT_W  instructions retired in RUN.
REQ-014 done  out  1  run finished (HALTED or TIMEOUT), sticky.
REQ-015 pass  out  1  high in HALTED when captured halt_code is zero.
REQ-016 timeout  out  1  high in TIMEOUT.
REQ-017 exit_code  out  32  captured halt_code; zero until a halt.
REQ-018 state  out  2  encoded FSM state for benches and waveform debug.

Function
REQ-019 FSM states SHALL be RST_HOLD(0), RUN(1), HALTED(2), TIMEOUT(3).
REQ-020 RST_HOLD: core_reset=1; hold counter increments each cycle; at count RST_CYCLES-1 the next state SHALL be RUN.
REQ-021 RUN: core_reset=0; cycle_cnt increments by 1 each cycle.
REQ-022 RUN: instret_cnt SHALL add the popcount of commit_valid each cycle (0..NCH).
REQ-023 Both counters SHALL saturate at all-ones and never wrap.
REQ-024 RUN and halt_req=1: exit_code<=halt_code, next state HALTED; commits in the same cycle are still counted.
REQ-025 Stall counter resets to 0 on any commit_valid bit and increments otherwise; reaching STALL_LIMIT (nonzero) SHALL enter TIMEOUT.
REQ-026 cycle_cnt reaching MAX_CYCLES (nonzero) SHALL enter TIMEOUT.
REQ-027 Simultaneous halt_req and timeout condition: halt SHALL win (HALTED).
REQ-028 HALTED and TIMEOUT are terminal: counters freeze, inputs ignored, core_reset stays 0, until reset.
REQ-029 done=1 in HALTED or TIMEOUT; pass=1 only in HALTED with exit_code==0; timeout=1 only in TIMEOUT.
REQ-030 commit_valid and halt_req SHALL be ignored outside RUN.
REQ-031 All outputs SHALL be registered or derived only from registered state (no input-to-output combinational path).

Reset
REQ-032 reset=1 SHALL asynchronously force state=RST_HOLD, core_reset=1, all counters 0, exit_code=0, done/pass/timeout=0.
REQ-033 reset asserted mid-RUN or in a terminal state SHALL abort immediately and restart the full RST_CYCLES hold after release.
REQ-034 core_reset SHALL assert asynchronously with reset and deassert only synchronously to clock.

Structure
REQ-035 Shared package npc_sim_pkg SHALL hold the state enum, state encodings and the 32-bit exit-code width constant.
REQ-036 One sub-module npc_popcount (parametrised by NCH) SHALL compute the commit count; everything else lives in npc_sim_ctrl.

Verification
REQ-037 Reset pulse, RST_CYCLES=4 -> core_reset high 4 cycles after release, then state=RUN, cycle_cnt counts 1,2,3...
REQ-038 NCH=2, commit_valid=2'b11 for 10 cycles then 2'b01 for 5 -> instret_cnt=25.
REQ-039 halt_req with halt_code=0 after 100 RUN cycles -> HALTED, done=1, pass=1, cycle_cnt frozen at 100; halt_code=3 -> pass=0, exit_code=3.
REQ-040 STALL_LIMIT=16, no commits -> TIMEOUT after 16 RUN cycles, timeout=1, done=1, pass=0.
REQ-041 halt_req in the same cycle as the stall limit hit -> HALTED, timeout=0.
REQ-042 CNT_W=4, 20 RUN cycles -> cycle_cnt saturates at 15; reset mid-RUN -> outputs cleared instantly, hold sequence repeats.

Source files
------------

// File: rtl/npc_sim_pkg.sv
// Shared definitions for the simulation run controller: FSM state
// encoding and the fixed widths used across the controller files.
package npc_sim_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALTED   = 2'd2,
    TIMEOUT  = 2'd3
  } sim_state_e;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned EXIT_W  = 32;
  // Commit count per cycle is at most 4 channels, so 3 bits suffice.
  localparam int unsigned POP_W   = 3;
  // Reset-hold counter; RST_CYCLES tops out at 255.
  localparam int unsigned HOLD_W  = 8;

endpackage

// File: rtl/npc_popcount.sv
// Counts the number of set commit-valid bits in one cycle.
module npc_popcount
  import npc_sim_pkg::*;
#(
  parameter int unsigned NCH = 1
) (
  input  logic [NCH-1:0]   vec,
  output logic [POP_W-1:0] count
);

  // Sum the individual channel bits.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      count = count + POP_W'(vec[i]);
    end
  end

endmodule

// File: rtl/npc_sim_ctrl.sv
// Simulation run controller: holds the core in reset, counts cycles and
// retired instructions while it runs, and records how the run ended
// (halt with exit code, or stall/cycle-limit timeout).
module npc_sim_ctrl
  import npc_sim_pkg::*;
#(
  parameter int unsigned NCH         = 1,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned MAX_CYCLES  = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NCH-1:0]     commit_valid,
  input  logic               halt_req,
  input  logic [EXIT_W-1:0]  halt_code,
  output logic               core_reset,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [EXIT_W-1:0]  exit_code,
  output logic [STATE_W-1:0] state
);

  // Wide enough to compare the cycle counter against MAX_CYCLES without
  // truncating either side.
  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;
  // Sum width for the instret add, with one carry bit for saturation.
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [31:0]       STALL_MAX = 32'(STALL_LIMIT);

  sim_state_e          state_q;
  sim_state_e          state_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [31:0]         stall_q;
  logic [31:0]         stall_d;
  logic [CNT_W-1:0]    cycle_d;
  logic [CNT_W-1:0]    instret_d;
  logic [SUM_W-1:0]    instret_sum;
  logic [POP_W-1:0]    pop;
  logic                stall_hit;
  logic                cycle_hit;

  npc_popcount #(
    .NCH (NCH)
  ) u_popcount (
    .vec   (commit_valid),
    .count (pop)
  );

  // Saturating next values of the run counters and the timeout conditions.
  always_comb begin
    cycle_d     = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    instret_sum = SUM_W'(instret_cnt) + SUM_W'(pop);
    instret_d   = (instret_sum[SUM_W-1:CNT_W] != '0) ? '1 : instret_sum[CNT_W-1:0];
    if (|commit_valid) begin
      stall_d = '0;
    end else begin
      stall_d = (stall_q == '1) ? stall_q : stall_q + 32'd1;
    end
    stall_hit = (STALL_LIMIT != 0) && (stall_d == STALL_MAX);
    cycle_hit = (MAX_CYCLES != 0) && (CMP_W'(cycle_d) == CMP_W'(MAX_CYCLES));
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a halt takes priority over any timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (stall_hit || cycle_hit) begin
          state_d = TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Counters and exit code only move in their owning state; terminal states freeze them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      stall_q     <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      exit_code   <= '0;
    end else begin
      if (state_q == RST_HOLD) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
      if (state_q == RUN) begin
        cycle_cnt   <= cycle_d;
        instret_cnt <= instret_d;
        stall_q     <= stall_d;
        if (halt_req) exit_code <= halt_code;
      end
    end
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    core_reset = (state_q == RST_HOLD);
    done       = (state_q == HALTED) || (state_q == TIMEOUT);
    pass       = (state_q == HALTED) && (exit_code == '0);
    timeout    = (state_q == TIMEOUT);
    state      = state_q;
  end

endmodule

// File: tb/tb_npc_sim_ctrl.sv
// Directed bench for npc_sim_ctrl using three parameterisations.
module tb_npc_sim_ctrl;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_TO   = 2'd3;
  // Flags packed as {core_reset, done, pass, timeout}.
  localparam logic [3:0] F_HOLD = 4'b1000;
  localparam logic [3:0] F_RUN  = 4'b0000;
  localparam logic [3:0] F_PASS = 4'b0110;
  localparam logic [3:0] F_BAD  = 4'b0100;
  localparam logic [3:0] F_TO   = 4'b0101;

  logic clock;
  logic reset;

  // DUT A: NCH=2, 64-bit counters, hold 4, stall limit 16.
  logic [1:0]  a_cv;
  logic        a_halt;
  logic [31:0] a_code;
  logic        a_core_reset, a_done, a_pass, a_timeout;
  logic [63:0] a_cycle, a_instret;
  logic [31:0] a_exit;
  logic [1:0]  a_state;

  // DUT B: NCH=4, 4-bit counters, hold 3, no watchdogs.
  logic [3:0]  b_cv;
  logic        b_halt;
  logic [31:0] b_code;
  logic        b_core_reset, b_done, b_pass, b_timeout;
  logic [3:0]  b_cycle, b_instret;
  logic [31:0] b_exit;
  logic [1:0]  b_state;

  // DUT C: NCH=1, 16-bit counters, hold 1, cycle limit 10.
  logic [0:0]  c_cv;
  logic        c_halt;
  logic [31:0] c_code;
  logic        c_core_reset, c_done, c_pass, c_timeout;
  logic [15:0] c_cycle, c_instret;
  logic [31:0] c_exit;
  logic [1:0]  c_state;

  int checks = 0;
  int errors = 0;

  npc_sim_ctrl #(.NCH(2), .CNT_W(64), .RST_CYCLES(4), .STALL_LIMIT(16), .MAX_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .commit_valid(a_cv), .halt_req(a_halt), .halt_code(a_code),
    .core_reset(a_core_reset), .cycle_cnt(a_cycle), .instret_cnt(a_instret), .done(a_done),
    .pass(a_pass), .timeout(a_timeout), .exit_code(a_exit), .state(a_state)
  );

  npc_sim_ctrl #(.NCH(4), .CNT_W(4), .RST_CYCLES(3), .STALL_LIMIT(0), .MAX_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .commit_valid(b_cv), .halt_req(b_halt), .halt_code(b_code),
    .core_reset(b_core_reset), .cycle_cnt(b_cycle), .instret_cnt(b_instret), .done(b_done),
    .pass(b_pass), .timeout(b_timeout), .exit_code(b_exit), .state(b_state)
  );

  npc_sim_ctrl #(.NCH(1), .CNT_W(16), .RST_CYCLES(1), .STALL_LIMIT(0), .MAX_CYCLES(10)) dut_c (
    .clock(clock), .reset(reset), .commit_valid(c_cv), .halt_req(c_halt), .halt_code(c_code),
    .core_reset(c_core_reset), .cycle_cnt(c_cycle), .instret_cnt(c_instret), .done(c_done),
    .pass(c_pass), .timeout(c_timeout), .exit_code(c_exit), .state(c_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  cv;
    logic        halt;
    logic [31:0] code;
    logic [1:0]  st;
    logic [63:0] cyc;
    logic [63:0] ins;
    logic [3:0]  fl;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [1:0] st, input logic [63:0] cyc,
                       input logic [63:0] ins, input logic [3:0] fl, input logic [31:0] ex);
    chk({tag, ".a.state"},   64'(a_state), 64'(st));
    chk({tag, ".a.cycle"},   a_cycle, cyc);
    chk({tag, ".a.instret"}, a_instret, ins);
    chk({tag, ".a.flags"},   64'({a_core_reset, a_done, a_pass, a_timeout}), 64'(fl));
    chk({tag, ".a.exit"},    64'(a_exit), 64'(ex));
  endtask

  task automatic chk_b(input string tag, input logic [1:0] st, input logic [3:0] cyc,
                       input logic [3:0] ins, input logic [3:0] fl);
    chk({tag, ".b.state"},   64'(b_state), 64'(st));
    chk({tag, ".b.cycle"},   64'(b_cycle), 64'(cyc));
    chk({tag, ".b.instret"}, 64'(b_instret), 64'(ins));
    chk({tag, ".b.flags"},   64'({b_core_reset, b_done, b_pass, b_timeout}), 64'(fl));
  endtask

  task automatic chk_c(input string tag, input logic [1:0] st, input logic [15:0] cyc,
                       input logic [15:0] ins, input logic [3:0] fl, input logic [31:0] ex);
    chk({tag, ".c.state"},   64'(c_state), 64'(st));
    chk({tag, ".c.cycle"},   64'(c_cycle), 64'(cyc));
    chk({tag, ".c.instret"}, 64'(c_instret), 64'(ins));
    chk({tag, ".c.flags"},   64'({c_core_reset, c_done, c_pass, c_timeout}), 64'(fl));
    chk({tag, ".c.exit"},    64'(c_exit), 64'(ex));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Quiet all inputs, pulse reset away from a clock edge, release just after an edge.
  task automatic do_reset();
    a_cv = '0; a_halt = 1'b0; a_code = '0;
    b_cv = '0; b_halt = 1'b0; b_code = '0;
    c_cv = '0; c_halt = 1'b0; c_code = '0;
    #3 reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_halt(input logic [31:0] code, input logic [3:0] fl);
    do_reset();
    repeat (4) tick();
    chk_a("halt_entry", S_RUN, 64'd0, 64'd0, F_RUN, 32'd0);
    a_cv = 2'b01;
    repeat (99) tick();
    a_halt = 1'b1;
    a_code = code;
    tick();
    a_halt = 1'b0;
    chk_a("halt_hit", S_HALT, 64'd100, 64'd100, fl, code);
    a_cv = 2'b11;
    a_code = 32'hFFFF_FFFF;
    repeat (5) tick();
    chk_a("halt_frozen", S_HALT, 64'd100, 64'd100, fl, code);
    #3 reset = 1'b1;
    #1;
    chk_a("halt_async_rst", S_HOLD, 64'd0, 64'd0, F_HOLD, 32'd0);
  endtask

  logic [3:0] b_seq [6];
  logic [3:0] b_exp [6];

  initial begin
    reset = 1'b0;
    a_cv = '0; a_halt = 1'b0; a_code = '0;
    b_cv = '0; b_halt = 1'b0; b_code = '0;
    c_cv = '0; c_halt = 1'b0; c_code = '0;

    // Reset applied before any clock edge: values must come from the async path.
    #3 reset = 1'b1;
    #1;
    chk_a("por", S_HOLD, 64'd0, 64'd0, F_HOLD, 32'd0);
    chk_b("por", S_HOLD, 4'd0, 4'd0, F_HOLD);
    chk_c("por", S_HOLD, 16'd0, 16'd0, F_HOLD, 32'd0);
    tick();
    reset = 1'b0;

    // Hold length on A: core_reset high for four edges after release.
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_a($sformatf("hold%0d", i), S_HOLD, 64'd0, 64'd0, F_HOLD, 32'd0);
    end
    tick();
    chk_a("hold_done", S_RUN, 64'd0, 64'd0, F_RUN, 32'd0);

    // Table of per-cycle vectors for A.
    for (int k = 1; k <= 10; k++)
      tbl.push_back('{2'b11, 1'b0, 32'd0, S_RUN, 64'(k), 64'(2 * k), F_RUN, 32'd0});
    for (int j = 1; j <= 5; j++)
      tbl.push_back('{2'b01, 1'b0, 32'd0, S_RUN, 64'(10 + j), 64'(20 + j), F_RUN, 32'd0});
    for (int j = 1; j <= 3; j++)
      tbl.push_back('{2'b00, 1'b0, 32'd0, S_RUN, 64'(15 + j), 64'd25, F_RUN, 32'd0});
    tbl.push_back('{2'b10, 1'b0, 32'd0, S_RUN,  64'd19, 64'd26, F_RUN,  32'd0});
    tbl.push_back('{2'b11, 1'b1, 32'd0, S_HALT, 64'd20, 64'd28, F_PASS, 32'd0});
    tbl.push_back('{2'b11, 1'b1, 32'd5, S_HALT, 64'd20, 64'd28, F_PASS, 32'd0});
    tbl.push_back('{2'b00, 1'b0, 32'd9, S_HALT, 64'd20, 64'd28, F_PASS, 32'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      a_cv   = tbl[i].cv;
      a_halt = tbl[i].halt;
      a_code = tbl[i].code;
      tick();
      chk_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].cyc, tbl[i].ins, tbl[i].fl, tbl[i].ex);
    end

    // Halt after 100 RUN cycles, passing and failing exit codes.
    run_halt(32'd0, F_PASS);
    run_halt(32'd3, F_BAD);

    // Stall watchdog: 16 idle RUN cycles.
    do_reset();
    repeat (4) tick();
    repeat (15) tick();
    chk_a("stall15", S_RUN, 64'd15, 64'd0, F_RUN, 32'd0);
    tick();
    chk_a("stall16", S_TO, 64'd16, 64'd0, F_TO, 32'd0);
    a_halt = 1'b1; a_code = 32'd7; a_cv = 2'b11;
    repeat (3) tick();
    a_halt = 1'b0;
    chk_a("to_frozen", S_TO, 64'd16, 64'd0, F_TO, 32'd0);

    // A single commit restarts the stall count.
    do_reset();
    repeat (4) tick();
    repeat (10) tick();
    a_cv = 2'b10;
    tick();
    a_cv = 2'b00;
    repeat (15) tick();
    chk_a("stall_rearm", S_RUN, 64'd26, 64'd1, F_RUN, 32'd0);
    tick();
    chk_a("stall_rearm_to", S_TO, 64'd27, 64'd1, F_TO, 32'd0);

    // Halt in the same cycle as the stall limit wins.
    do_reset();
    repeat (4) tick();
    repeat (15) tick();
    a_halt = 1'b1; a_code = 32'd0;
    tick();
    a_halt = 1'b0;
    chk_a("halt_vs_stall", S_HALT, 64'd16, 64'd0, F_PASS, 32'd0);

    // B: popcount across four channels and 4-bit saturation.
    do_reset();
    repeat (2) tick();
    chk_b("b_hold2", S_HOLD, 4'd0, 4'd0, F_HOLD);
    tick();
    chk_b("b_run", S_RUN, 4'd0, 4'd0, F_RUN);
    b_seq = '{4'b1011, 4'b0110, 4'b1111, 4'b1111, 4'b1000, 4'b1111};
    b_exp = '{4'd3, 4'd5, 4'd9, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i < 6; i++) begin
      b_cv = b_seq[i];
      tick();
      chk_b($sformatf("b_pop%0d", i), S_RUN, 4'(i + 1), b_exp[i], F_RUN);
    end
    b_cv = 4'b0000;
    repeat (9) tick();
    chk_b("b_cyc15", S_RUN, 4'd15, 4'd15, F_RUN);
    repeat (5) tick();
    chk_b("b_sat20", S_RUN, 4'd15, 4'd15, F_RUN);

    // Reset mid-RUN clears immediately and restarts the hold.
    #3 reset = 1'b1;
    #1;
    chk_b("b_async_rst", S_HOLD, 4'd0, 4'd0, F_HOLD);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    chk_b("b_rehold", S_HOLD, 4'd0, 4'd0, F_HOLD);
    tick();
    chk_b("b_rerun", S_RUN, 4'd0, 4'd0, F_RUN);
    tick();
    chk_b("b_recount", S_RUN, 4'd1, 4'd0, F_RUN);

    // C: single-cycle hold and global cycle limit.
    do_reset();
    tick();
    chk_c("c_run", S_RUN, 16'd0, 16'd0, F_RUN, 32'd0);
    c_cv = 1'b1;
    repeat (9) tick();
    chk_c("c_cyc9", S_RUN, 16'd9, 16'd9, F_RUN, 32'd0);
    tick();
    chk_c("c_limit", S_TO, 16'd10, 16'd10, F_TO, 32'd0);

    // C: halt on the limit cycle wins, nonzero code fails the run.
    do_reset();
    tick();
    c_cv = 1'b0;
    repeat (9) tick();
    c_halt = 1'b1; c_code = 32'h0000_0007;
    tick();
    c_halt = 1'b0;
    chk_c("c_halt_vs_limit", S_HALT, 16'd10, 16'd0, F_BAD, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
